// File: rtl/ow_slot_decoder_if.sv
// One-wire slave decoder signal bundle: line sample, control inputs and
// the byte/status outputs. The master side drives the line and controls,
// the slave side is the decoder itself.
interface ow_slot_decoder_if;
  logic       bus;
  logic       enable;
  logic       data_ready;
  logic       clear_ovr;
  logic [7:0] data_out;
  logic       data_valid;
  logic       reset_det;
  logic       frame_err;
  logic       overrun;

  modport master (
    output bus, enable, data_ready, clear_ovr,
    input  data_out, data_valid, reset_det, frame_err, overrun
  );

  modport slave (
    input  bus, enable, data_ready, clear_ovr,
    output data_out, data_valid, reset_det, frame_err, overrun
  );
endinterface

// File: rtl/ow_slot_decoder.sv
// One-wire write-slot decoder: measures each low pulse on the line,
// turns legal slots into bits (LSB first), flags frame errors and bus
// resets, and hands completed bytes out over a valid/ready pair.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | line high, waiting for a falling edge
// LOW       | inside a low pulse, counting its width
// WAIT_HIGH | reset pulse recognized, waiting for line release
//
// Timing parameters must satisfy T_SAMPLE < T_SLOT_MAX < T_RESET_MIN <= 1023.
module ow_slot_decoder #(
  parameter int unsigned T_SAMPLE    = 15,
  parameter int unsigned T_SLOT_MAX  = 120,
  parameter int unsigned T_RESET_MIN = 480
) (
  input logic          clk,
  input logic          reset,
  ow_slot_decoder_if.slave ow
);

  typedef enum logic [1:0] {IDLE, LOW, WAIT_HIGH} state_t;

  localparam logic [9:0] CNT_MAX   = 10'd1023;
  localparam logic [9:0] SAMPLE_AT = 10'(T_SAMPLE);
  localparam logic [9:0] SLOT_MAX  = 10'(T_SLOT_MAX);
  localparam logic [9:0] RESET_AT  = 10'(T_RESET_MIN);

  logic       bus_m, bus_s, bus_d;
  state_t     state;
  logic [9:0] cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       samp_bit;
  logic [7:0] data_out_q;
  logic       data_valid_q, reset_det_q, frame_err_q, overrun_q;

  logic       fall;
  logic       slot_bit;
  logic       slot_ok;
  logic       byte_done;
  logic [7:0] next_byte;

  assign ow.data_out   = data_out_q;
  assign ow.data_valid = data_valid_q;
  assign ow.reset_det  = reset_det_q;
  assign ow.frame_err  = frame_err_q;
  assign ow.overrun    = overrun_q;

  assign fall = bus_d & ~bus_s;

  // A line released before the sample point reads as 1; if the slot ends
  // exactly on the sample cycle the live (high) level is the bit.
  assign slot_bit  = (cnt == SAMPLE_AT) ? bus_s : samp_bit;
  assign slot_ok   = (state == LOW) && bus_s && (cnt < RESET_AT) && (cnt <= SLOT_MAX);
  assign byte_done = ow.enable && slot_ok && (bit_cnt == 3'd7);

  // Partial byte with the current slot bit merged in at its position
  always_comb begin
    next_byte          = shreg;
    next_byte[bit_cnt] = slot_bit;
  end

  // Two-flop synchronizer plus a delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_m <= 1'b1;
      bus_s <= 1'b1;
      bus_d <= 1'b1;
    end else begin
      bus_m <= ow.bus;
      bus_s <= bus_m;
      bus_d <= bus_s;
    end
  end

  // Slot FSM, byte assembly and output handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      samp_bit     <= 1'b1;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      reset_det_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      reset_det_q <= 1'b0;
      frame_err_q <= 1'b0;

      // Set after clear so a same-cycle overrun wins
      if (ow.clear_ovr) overrun_q <= 1'b0;

      if (byte_done) begin
        if (!data_valid_q || ow.data_ready) begin
          data_out_q   <= next_byte;
          data_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (data_valid_q && ow.data_ready) begin
        data_valid_q <= 1'b0;
      end

      if (!ow.enable) begin
        state    <= IDLE;
        cnt      <= '0;
        bit_cnt  <= '0;
        shreg    <= '0;
        samp_bit <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              cnt      <= '0;
              samp_bit <= 1'b1;
              state    <= LOW;
            end
          end
          LOW: begin
            if (cnt >= RESET_AT) begin
              reset_det_q <= 1'b1;
              bit_cnt     <= '0;
              shreg       <= '0;
              state       <= WAIT_HIGH;
            end else if (bus_s) begin
              if (cnt <= SLOT_MAX) begin
                shreg   <= (bit_cnt == 3'd7) ? 8'h00 : next_byte;
                bit_cnt <= bit_cnt + 3'd1;
              end else begin
                frame_err_q <= 1'b1;
                bit_cnt     <= '0;
                shreg       <= '0;
              end
              state <= IDLE;
            end else begin
              if (cnt != CNT_MAX) cnt <= cnt + 10'd1;
              if (cnt == SAMPLE_AT) samp_bit <= bus_s;
            end
          end
          WAIT_HIGH: begin
            if (bus_s) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ow_slot_decoder.sv
`timescale 1ns/1ps
// Randomized self-checking bench for the one-wire slot decoder. A slot-level
// reference model turns each low-pulse width into a bit, a frame error or a
// bus reset and tracks the byte handshake.
module tb_ow_slot_decoder;
  localparam int T_SAMPLE    = 15;
  localparam int T_SLOT_MAX  = 120;
  localparam int T_RESET_MIN = 480;

  logic clk = 1'b0;
  logic reset;
  ow_slot_decoder_if ifc ();

  ow_slot_decoder #(
    .T_SAMPLE(T_SAMPLE), .T_SLOT_MAX(T_SLOT_MAX), .T_RESET_MIN(T_RESET_MIN)
  ) dut (
    .clk(clk), .reset(reset), .ow(ifc)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit       m_bits[$];
  bit [7:0] m_out = 8'h00;
  bit       m_valid = 1'b0;
  bit       m_ovr = 1'b0;
  int       m_fe = 0;
  int       m_rd = 0;

  // pulse monitor (counts only)
  int   rd_hi = 0, rd_rise = 0, fe_hi = 0, fe_rise = 0;
  logic rd_prev = 1'b0, fe_prev = 1'b0;
  always @(negedge clk) begin
    if (ifc.reset_det === 1'b1) rd_hi++;
    if (ifc.reset_det === 1'b1 && !rd_prev) rd_rise++;
    rd_prev = (ifc.reset_det === 1'b1);
    if (ifc.frame_err === 1'b1) fe_hi++;
    if (ifc.frame_err === 1'b1 && !fe_prev) fe_rise++;
    fe_prev = (ifc.frame_err === 1'b1);
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One low pulse of width w: short pulses are 1s, long legal ones 0s,
  // too long for a slot is a frame error, reset-length clears everything.
  function automatic void model_slot(input int w, input bit hs);
    bit [7:0] b;
    if (w <= T_SLOT_MAX) begin
      m_bits.push_back(w <= T_SAMPLE);
      if (m_bits.size() == 8) begin
        for (int i = 0; i < 8; i++) b[i] = m_bits[i];
        m_bits.delete();
        if (!m_valid || hs) begin
          m_out   = b;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end else begin
      m_bits.delete();
      if (w >= T_RESET_MIN) m_rd++;
      else m_fe++;
    end
  endfunction

  task automatic slot(input int w, input int rec);
    ifc.bus = 1'b0;
    tick(w);
    ifc.bus = 1'b1;
    model_slot(w, ifc.data_ready);
    tick(rec);
    if (ifc.data_ready) m_valid = 1'b0;
  endtask

  function automatic int bit_width(input bit v);
    bit_width = v ? int'($urandom_range(3, 10)) : int'($urandom_range(25, 110));
  endfunction

  task automatic send_bits(input bit [7:0] b, input int n);
    for (int i = 0; i < n; i++) slot(bit_width(b[i]), int'($urandom_range(6, 40)));
  endtask

  task automatic send_fixed(input bit [7:0] b);
    for (int i = 0; i < 8; i++) slot(b[i] ? 5 : 70, 30);
  endtask

  task automatic set_ready(input bit r);
    ifc.data_ready = r;
    tick(1);
    if (r) m_valid = 1'b0;
  endtask

  task automatic pulse_clear_ovr();
    ifc.clear_ovr = 1'b1;
    tick(1);
    ifc.clear_ovr = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifc.bus = 1'b1; ifc.enable = 1'b1; ifc.data_ready = 1'b0; ifc.clear_ovr = 1'b0;
    tick(3);
    checks++; if (ifc.data_out !== 8'h00) begin errors++; $display("FAIL rst_data_out: got %h want 00", ifc.data_out); end
    checks++; if (ifc.data_valid !== 1'b0) begin errors++; $display("FAIL rst_data_valid: got %b want 0", ifc.data_valid); end
    checks++; if (ifc.reset_det !== 1'b0) begin errors++; $display("FAIL rst_reset_det: got %b want 0", ifc.reset_det); end
    checks++; if (ifc.frame_err !== 1'b0) begin errors++; $display("FAIL rst_frame_err: got %b want 0", ifc.frame_err); end
    checks++; if (ifc.overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", ifc.overrun); end
    reset = 1'b0;
    tick(4);
    checks++; if (ifc.data_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b want 0", ifc.data_valid); end
  endtask

  task automatic test_write_a5();
    bit [7:0] b = 8'hA5;
    for (int i = 0; i < 7; i++) slot(b[i] ? 5 : 70, 30);
    ifc.bus = 1'b0;
    tick(5);
    ifc.bus = 1'b1;
    model_slot(5, ifc.data_ready);
    tick(2);
    checks++; if (ifc.data_valid !== 1'b0) begin errors++; $display("FAIL a5_early_valid: got %b want 0", ifc.data_valid); end
    tick(1);
    checks++; if (ifc.data_valid !== 1'b1) begin errors++; $display("FAIL a5_valid_latency: got %b want 1", ifc.data_valid); end
    checks++; if (ifc.data_out !== m_out) begin errors++; $display("FAIL a5_data: got %h want %h", ifc.data_out, m_out); end
    tick(30);
    set_ready(1'b1);
    set_ready(1'b0);
    checks++; if (ifc.data_valid !== 1'b0) begin errors++; $display("FAIL a5_consume: got %b want 0", ifc.data_valid); end
  endtask

  task automatic test_reset_pulse();
    int r0 = rd_hi, rr0 = rd_rise, f0 = fe_hi;
    send_bits(8'h07, 3);
    slot(600, 30);
    checks++; if (rd_rise - rr0 !== 1) begin errors++; $display("FAIL rstpulse_count: got %0d want 1", rd_rise - rr0); end
    checks++; if (rd_hi - r0 !== 1) begin errors++; $display("FAIL rstpulse_width: got %0d want 1", rd_hi - r0); end
    checks++; if (fe_hi - f0 !== 0) begin errors++; $display("FAIL rstpulse_no_fe: got %0d want 0", fe_hi - f0); end
    send_fixed(8'h3C);
    checks++; if (ifc.data_out !== m_out || m_out !== 8'h3C) begin errors++; $display("FAIL rstpulse_data: got %h want %h", ifc.data_out, m_out); end
    checks++; if (ifc.data_valid !== 1'b1) begin errors++; $display("FAIL rstpulse_valid: got %b want 1", ifc.data_valid); end
    set_ready(1'b1);
    set_ready(1'b0);
  endtask

  task automatic test_frame_err();
    int fr0 = fe_rise, f0 = fe_hi;
    send_bits(8'h02, 2);
    slot(200, 30);
    checks++; if (fe_rise - fr0 !== 1) begin errors++; $display("FAIL fe_count: got %0d want 1", fe_rise - fr0); end
    checks++; if (fe_hi - f0 !== 1) begin errors++; $display("FAIL fe_width: got %0d want 1", fe_hi - f0); end
    send_fixed(8'h01);
    checks++; if (ifc.data_out !== m_out || m_out !== 8'h01) begin errors++; $display("FAIL fe_data: got %h want %h", ifc.data_out, m_out); end
    set_ready(1'b1);
    set_ready(1'b0);
  endtask

  task automatic test_overrun();
    send_fixed(8'h11);
    checks++; if (ifc.data_out !== 8'h11) begin errors++; $display("FAIL ovr_first: got %h want 11", ifc.data_out); end
    send_fixed(8'h22);
    checks++; if (ifc.data_out !== 8'h11) begin errors++; $display("FAIL ovr_kept: got %h want 11", ifc.data_out); end
    checks++; if (ifc.overrun !== m_ovr || !m_ovr) begin errors++; $display("FAIL ovr_set: got %b want %b", ifc.overrun, m_ovr); end
    pulse_clear_ovr();
    checks++; if (ifc.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", ifc.overrun); end
    checks++; if (ifc.data_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b want 1", ifc.data_valid); end
    set_ready(1'b1);
    set_ready(1'b0);
  endtask

  task automatic test_back_to_back();
    bit [7:0] b = 8'h22;
    send_fixed(8'h11);
    for (int i = 0; i < 7; i++) slot(b[i] ? 5 : 70, 30);
    ifc.bus = 1'b0;
    tick(70);
    ifc.bus = 1'b1;
    tick(2);
    ifc.data_ready = 1'b1;
    model_slot(70, 1'b1);
    tick(1);
    ifc.data_ready = 1'b0;
    checks++; if (ifc.data_out !== 8'h22) begin errors++; $display("FAIL b2b_data: got %h want 22", ifc.data_out); end
    checks++; if (ifc.overrun !== 1'b0) begin errors++; $display("FAIL b2b_no_ovr: got %b want 0", ifc.overrun); end
    tick(1);
    checks++; if (ifc.data_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", ifc.data_valid); end
    tick(30);
  endtask

  task automatic test_random();
    bit [7:0] b;
    bit r;
    for (int it = 0; it < 16; it++) begin
      r = bit'($urandom_range(0, 1));
      set_ready(r);
      if ($urandom_range(0, 3) == 0) pulse_clear_ovr();
      case ($urandom_range(0, 5))
        0: begin send_bits(8'($urandom), int'($urandom_range(0, 7))); slot(int'($urandom_range(130, 460)), 20); end
        1: begin send_bits(8'($urandom), int'($urandom_range(0, 7))); slot(int'($urandom_range(490, 700)), 20); end
        2: begin
          send_bits(8'($urandom), int'($urandom_range(1, 7)));
          ifc.enable = 1'b0;
          tick(3);
          ifc.enable = 1'b1;
          m_bits.delete();
          tick(2);
        end
        default: ;
      endcase
      b = 8'($urandom);
      send_bits(b, 8);
      checks++; if (ifc.data_out !== m_out) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", it, ifc.data_out, m_out); end
      checks++; if (ifc.data_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", it, ifc.data_valid, m_valid); end
      checks++; if (ifc.overrun !== m_ovr) begin errors++; $display("FAIL rnd_ovr[%0d]: got %b want %b", it, ifc.overrun, m_ovr); end
    end
    checks++; if (fe_rise !== m_fe) begin errors++; $display("FAIL rnd_fe_total: got %0d want %0d", fe_rise, m_fe); end
    checks++; if (rd_rise !== m_rd) begin errors++; $display("FAIL rnd_rd_total: got %0d want %0d", rd_rise, m_rd); end
    checks++; if (fe_hi !== fe_rise) begin errors++; $display("FAIL rnd_fe_width: got %0d want %0d", fe_hi, fe_rise); end
    set_ready(1'b0);
  endtask

  task automatic test_async_reset();
    set_ready(1'b1);
    set_ready(1'b0);
    send_fixed(8'h5A);
    send_fixed(8'hC3);
    checks++; if (ifc.data_valid !== 1'b1 || ifc.overrun !== 1'b1) begin errors++; $display("FAIL arst_pre: got valid=%b ovr=%b want 1 1", ifc.data_valid, ifc.overrun); end
    send_bits(8'h0F, 4);
    ifc.bus = 1'b0;
    tick(8);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ifc.data_out !== 8'h00) begin errors++; $display("FAIL arst_data_out: got %h want 00", ifc.data_out); end
    checks++; if (ifc.data_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", ifc.data_valid); end
    checks++; if (ifc.overrun !== 1'b0) begin errors++; $display("FAIL arst_overrun: got %b want 0", ifc.overrun); end
    checks++; if (ifc.reset_det !== 1'b0 || ifc.frame_err !== 1'b0) begin errors++; $display("FAIL arst_pulses: got rd=%b fe=%b want 0 0", ifc.reset_det, ifc.frame_err); end
    ifc.bus = 1'b1;
    m_bits.delete();
    m_out = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(3);
    send_fixed(8'hFF);
    checks++; if (ifc.data_out !== m_out || m_out !== 8'hFF) begin errors++; $display("FAIL arst_fresh_data: got %h want %h", ifc.data_out, m_out); end
    checks++; if (ifc.data_valid !== 1'b1) begin errors++; $display("FAIL arst_fresh_valid: got %b want 1", ifc.data_valid); end
    checks++; if (ifc.overrun !== 1'b0) begin errors++; $display("FAIL arst_fresh_ovr: got %b want 0", ifc.overrun); end
  endtask

  initial begin
    test_reset();
    test_write_a5();
    test_reset_pulse();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
